// File: rtl/dff_bank_pkg.sv
// -----------------------------------------------------------------------------
// Module  : dff_bank_pkg
// Purpose : Shared op / state encodings for the shared register bank arbiter.
// Rev     : 1.0  initial release
// -----------------------------------------------------------------------------
`default_nettype none

package dff_bank_pkg;

    localparam int OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        OP_LOAD   = 2'b00,
        OP_SET    = 2'b01,
        OP_CLEAR  = 2'b10,
        OP_TOGGLE = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_EXEC  = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/dff_bank_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// Module  : rr_pick
// Purpose : Combinational round-robin selector: first valid index at or after ptr.
// Rev     : 1.0  initial release
// -----------------------------------------------------------------------------
`default_nettype none

module rr_pick #(
    parameter int NREQ  = 4,
    parameter int IDX_W = 2
) (
    input  logic [NREQ-1:0]  valid,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] winner,
    output logic             any_valid
);

    logic [IDX_W-1:0] w_idx;

    // Scan from the farthest offset down so the nearest valid index wins;
    // NREQ is a power of two, so the IDX_W-bit add wraps for free.
    always_comb begin
        winner    = '0;
        w_idx     = '0;
        any_valid = |valid;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_idx = ptr + IDX_W'(k);
            if (valid[w_idx]) begin
                winner = w_idx;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/dff_bank_arbiter.sv
// -----------------------------------------------------------------------------
// Module  : dff_bank_arbiter
// Purpose : Round-robin arbiter sharing one falling-edge register bank among
//           NREQ requesters issuing load/set/clear/toggle ops.
// Rev     : 1.0  initial release
// -----------------------------------------------------------------------------
`default_nettype none

module dff_bank_arbiter
    import dff_bank_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic                    pre,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [OP_W*NREQ-1:0]    req_op,
    input  logic [WIDTH*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]         grant,
    output logic [NREQ-1:0]         ack,
    output logic                    busy,
    output logic [WIDTH-1:0]        q
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t              r_state;
    state_t              w_next_state;
    logic [IDX_W-1:0]    r_ptr;
    logic [IDX_W-1:0]    r_owner;
    op_t                 r_op;
    logic [WIDTH-1:0]    r_data;
    logic [NREQ-1:0]     r_grant;
    logic [NREQ-1:0]     r_ack;
    logic [WIDTH-1:0]    r_q;

    logic [IDX_W-1:0]    w_winner;
    logic                w_any;
    logic [NREQ-1:0]     w_win_oh;
    logic [OP_W-1:0]     w_sel_op;
    logic [WIDTH-1:0]    w_sel_data;
    logic [WIDTH-1:0]    w_exec_q;

    rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .valid     (req_valid),
        .ptr       (r_ptr),
        .winner    (w_winner),
        .any_valid (w_any)
    );

    assign w_win_oh   = {{(NREQ-1){1'b0}}, 1'b1} << w_winner;
    assign w_sel_op   = req_op[OP_W*w_winner +: OP_W];
    assign w_sel_data = req_data[WIDTH*w_winner +: WIDTH];

    always_comb begin
        w_exec_q = r_q;
        case (r_op)
            OP_LOAD:   w_exec_q = r_data;
            OP_SET:    w_exec_q = r_q | r_data;
            OP_CLEAR:  w_exec_q = r_q & ~r_data;
            OP_TOGGLE: w_exec_q = r_q ^ r_data;
            default:   w_exec_q = r_q;
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_any) w_next_state = S_GRANT;
            S_GRANT: w_next_state = S_EXEC;
            S_EXEC:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(negedge clk or negedge clr) begin
        if (!clr) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Owner's op/data are captured at arbitration so later changes on the
    // request lines (including a dropped valid) cannot affect the write.
    always_ff @(negedge clk or negedge clr) begin
        if (!clr) begin
            r_ptr   <= '0;
            r_owner <= '0;
            r_op    <= OP_LOAD;
            r_data  <= '0;
            r_grant <= '0;
            r_ack   <= '0;
        end else begin
            r_ack <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_grant <= w_win_oh;
                        r_owner <= w_winner;
                        r_op    <= op_t'(w_sel_op);
                        r_data  <= w_sel_data;
                    end
                end
                S_EXEC: begin
                    r_ack   <= r_grant;
                    r_grant <= '0;
                    r_ptr   <= r_owner + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Preset wins over a same-edge EXEC write; the handshake still completes.
    always_ff @(negedge clk or negedge clr) begin
        if (!clr) begin
            r_q <= '0;
        end else if (!pre) begin
            r_q <= '1;
        end else if (r_state == S_EXEC) begin
            r_q <= w_exec_q;
        end
    end

    assign grant = r_grant;
    assign ack   = r_ack;
    assign busy  = (r_state != S_IDLE);
    assign q     = r_q;

endmodule

`default_nettype wire

// File: doc/dff_bank_arbiter.md
Name: dff_bank_arbiter

Overview:
- Round-robin arbiter and controller that shares one WIDTH-bit register bank among NREQ requesters.
- The bank is built from negedge D flip-flops with clear/preset.
- Each requester posts an operation (load, set bits, clear bits, toggle bits) with a data/mask word. The block grants one requester at a time, applies the op to the bank and acknowledges it.
- Sits between lab-level stimulus/FSM blocks and the shared storage register.

Parameters:
- WIDTH, 8, width of the shared register bank q.
- NREQ, 4, number of requesters (power of two, 2..8).

Ports:
- clk  input  1  clock; all state updates on the falling edge.
- clr  input  1  asynchronous active-low reset.
- pre  input  1  synchronous active-low preset, sampled on the falling edge of clk.
- req_valid  input  NREQ  per-requester request strobe, level.
- req_op  input  2*NREQ  per-requester op; requester i uses bits [2i+1:2i].
- req_data  input  WIDTH*NREQ  per-requester data/mask; requester i uses bits [WIDTH*i +: WIDTH].
- grant  output  NREQ  one-hot current owner; zero when idle.
- ack  output  NREQ  one-hot, one-cycle pulse when owner's op is applied.
- busy  output  1  high in GRANT and EXEC.
- q  output  WIDTH  shared register bank contents.

Behaviour:
- Reset (clr low, asynchronous):
  - q=0, grant=0, ack=0, busy=0, state=IDLE, round-robin pointer ptr=0.
  - clr low overrides pre and everything else.
  - Reset mid-transaction aborts it: no ack is issued.
- Ops (2-bit encoding):
  - 00 LOAD: q<=d.
  - 01 SET: q<=q|d.
  - 10 CLEAR: q<=q&~d.
  - 11 TOGGLE: q<=q^d.
  - All results are exactly WIDTH bits; no carries.
- FSM states: IDLE, GRANT, EXEC.
- IDLE:
  - If any req_valid is high, select the winner by round robin: the first valid index starting at ptr, wrapping NREQ-1 -> 0.
  - Register grant=onehot(winner), latch the winner's op and data, go to GRANT.
  - With no valid request, stay in IDLE.
- GRANT:
  - One-cycle hold so the requester observes grant.
  - Unconditionally go to EXEC.
  - If req_valid of the owner drops here, the latched op is still executed.
- EXEC:
  - Apply the latched op to q.
  - Pulse ack[winner] for exactly this cycle.
  - Set ptr=(winner+1) mod NREQ, clear grant, go to IDLE.
- Latency: request seen at falling edge k; grant high after k; q updated and ack high after k+2; next arbitration at k+3.
  - Max throughput is one op per 3 cycles.
- Handshake: the requester must drop req_valid in the cycle it sees ack. If req_valid is still high when the FSM is next in IDLE, it is a new request, subject to round robin.
- pre low:
  - q<=all ones on that edge, taking priority over any EXEC write in the same edge.
  - In EXEC, ack still pulses and ptr still advances, but the write is discarded.
  - pre does not alter FSM state or grant.
- Simultaneous requests: the lowest index at or after ptr wins. Starvation-free; any requester waits at most NREQ-1 transactions.
- req_op/req_data of non-owners are ignored.
- Invariants: grant and ack are each one-hot or zero; ack is only asserted for the bit set in grant during EXEC.

Decomposition:
- Shared package dff_bank_pkg holds:
  - typedef op_t {OP_LOAD=2'b00, OP_SET=2'b01, OP_CLEAR=2'b10, OP_TOGGLE=2'b11};
  - typedef state_t {S_IDLE, S_GRANT, S_EXEC};
  - localparam OP_W=2.
- One sub-module, rr_pick:
  - Combinational round-robin selector.
  - Inputs: valid[NREQ], ptr. Outputs: winner index, any_valid.
- Top holds the FSM, the latches and the q register.

Test Plan (WIDTH=8, NREQ=4):
- Reset and load: clr=0 then 1, pre=1; req0 LOAD 8'hA5 -> grant=4'b0001 one cycle after request, ack[0] pulses two cycles after request, q=8'hA5.
- Bit ops: from q=8'hA5, req1 SET 8'h0F -> q=8'hAF. Then req1 CLEAR 8'hA0 -> q=8'h0F. Then req2 TOGGLE 8'hFF -> q=8'hF0.
- Round-robin fairness: all four req_valid held high (each LOAD of its index) -> ack order 0,1,2,3,0; q sequence 0,1,2,3,0; no ack gaps other than 3-cycle spacing.
- Wrap and pointer: ptr=3 after serving req2, then req0 and req3 valid -> req3 served first, then req0.
- Preset collision: req0 LOAD 8'h12, pre=0 on its EXEC edge -> q=8'hFF, ack[0] still pulses. pre=0 in IDLE -> q=8'hFF, grant stays 0.
- Reset mid-operation: clr=0 asserted during GRANT -> grant=0, ack never pulses, q=0 immediately (asynchronous). After release, a pending req restarts from ptr=0.
